data_mem_resp: RTL and testbench

//  Responder for the PCPU data-memory port: serves loads and stores issued by the CPU on

---
 rtl/data_mem_resp.sv | 130 +++++++++++++
 tb/tb_data_mem_resp.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// data_mem_resp: data-memory responder for the PCPU data port.
// Holds the data RAM and a 16-byte MMIO window with a cycle counter,
// a RAM-store counter and a TOHOST FIFO drained over valid/ready.
module data_mem_resp #(
  parameter int          RAM_ADDR_W = 9,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic        data_we,
  input  logic [31:0] data_write,
  output logic [31:0] data_mem,
  output logic [31:0] tohost_data,
  output logic        tohost_valid,
  input  logic        tohost_ready
);

  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;
  localparam int RAM_WORDS = 2 ** RAM_ADDR_W;

  // Address decode; the byte offset within a word plays no role.
  logic                  unused_byte_off;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  hit_ram;
  logic                  hit_mmio;
  logic [1:0]            mmio_sel;
  logic                  wr_ram;
  logic                  wr_tohost;
  logic                  wr_status;

  assign unused_byte_off = ^data_addr[1:0];
  assign ram_idx   = data_addr[RAM_ADDR_W+1:2];
  assign hit_ram   = (data_addr[31:RAM_ADDR_W+2] == '0);
  assign hit_mmio  = (data_addr[31:4] == MMIO_BASE[31:4]);
  assign mmio_sel  = data_addr[3:2];
  assign wr_ram    = data_we && hit_ram;
  assign wr_tohost = data_we && hit_mmio && (mmio_sel == 2'd2);
  assign wr_status = data_we && hit_mmio && (mmio_sel == 2'd3);

  // Storage (no reset: contents survive rst)
  logic [31:0] ram      [RAM_WORDS];
  logic [31:0] fifo_mem [FIFO_DEPTH];

  // Control state
  logic [31:0]      cycle_cnt;
  logic [31:0]      stores_cnt;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W-1:0] fifo_cnt_nxt;
  logic             overflow;

  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        push_ok;
  logic [31:0] status_word;

  assign fifo_full    = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (fifo_cnt == '0);
  assign tohost_valid = !fifo_empty;
  assign pop          = tohost_valid && tohost_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok      = wr_tohost && (!fifo_full || pop);
  // Head is read from registered storage only; forced to 0 while empty.
  assign tohost_data  = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign status_word  = {23'd0, overflow, 6'(fifo_cnt), fifo_empty, fifo_full};

  // Next FIFO occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    case ({push_ok, pop})
      2'b10:   fifo_cnt_nxt = fifo_cnt + CNT_W'(1);
      2'b01:   fifo_cnt_nxt = fifo_cnt - CNT_W'(1);
      default: fifo_cnt_nxt = fifo_cnt;
    endcase
  end

  // Zero-latency load mux reflecting state before the current edge.
  always_comb begin
    data_mem = '0;
    if (hit_ram) begin
      data_mem = ram[ram_idx];
    end else if (hit_mmio) begin
      case (mmio_sel)
        2'd0:    data_mem = cycle_cnt;
        2'd1:    data_mem = stores_cnt;
        2'd2:    data_mem = '0;
        default: data_mem = status_word;
      endcase
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= data_write;
  end

  // FIFO slot write for accepted pushes.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= data_write;
  end

  // Counters, FIFO pointers/occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt  <= '0;
      stores_cnt <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (wr_ram)  stores_cnt <= stores_cnt + 32'd1;
      if (push_ok) wr_ptr     <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr     <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt_nxt;
      if (wr_tohost && fifo_full && !pop) begin
        overflow <= 1'b1;
      end else if (wr_status && data_write[8]) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: directed scenarios plus a randomized run,
// all compared against a queue/array reference model of the memory map.
module tb_data_mem_resp;

  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] RAM_BYTES  = 32'd2048;  // 512 words of 4 bytes
  localparam logic [31:0] MMIO       = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE    = MMIO + 32'h0;
  localparam logic [31:0] A_STORES   = MMIO + 32'h4;
  localparam logic [31:0] A_TOHOST   = MMIO + 32'h8;
  localparam logic [31:0] A_STATUS   = MMIO + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_addr = '0;
  logic        data_we = 1'b0;
  logic [31:0] data_write = '0;
  logic [31:0] data_mem;
  logic [31:0] tohost_data;
  logic        tohost_valid;
  logic        tohost_ready = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_cycle  = '0;
  logic [31:0] m_stores = '0;
  logic [31:0] m_fifo [$];
  logic        m_ovf    = 1'b0;

  data_mem_resp #(
    .RAM_ADDR_W(9),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MMIO_BASE (MMIO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_addr   (data_addr),
    .data_we     (data_we),
    .data_write  (data_write),
    .data_mem    (data_mem),
    .tohost_data (tohost_data),
    .tohost_valid(tohost_valid),
    .tohost_ready(tohost_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_status();
    return {23'd0, m_ovf, 6'(m_fifo.size()), (m_fifo.size() == 0), (m_fifo.size() == FIFO_DEPTH)};
  endfunction

  // Expected load value; returns 0 when the RAM word has never been written.
  function automatic bit m_load(input logic [31:0] a, output logic [31:0] v);
    logic [31:0] w;
    w = a & ~32'h3;
    v = '0;
    if (w < RAM_BYTES) begin
      if (!m_ram.exists(int'(w >> 2))) return 1'b0;
      v = m_ram[int'(w >> 2)];
    end else if (w == A_CYCLE)  v = m_cycle;
    else if (w == A_STORES)     v = m_stores;
    else if (w == A_TOHOST)     v = '0;
    else if (w == A_STATUS)     v = m_status();
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_head();
    return (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
  endfunction

  task automatic m_reset();
    m_cycle  = '0;
    m_stores = '0;
    m_fifo.delete();
    m_ovf    = 1'b0;
  endtask

  task automatic setin(input logic [31:0] a, input logic we, input logic [31:0] d);
    data_addr  = a;
    data_we    = we;
    data_write = d;
  endtask

  // One clock with the current inputs; model updated with the same edge.
  task automatic tick();
    logic [31:0] w;
    bit full, pop, push;
    w    = data_addr & ~32'h3;
    full = (m_fifo.size() == FIFO_DEPTH);
    pop  = (m_fifo.size() > 0) && tohost_ready;
    push = data_we && (w == A_TOHOST);
    @(posedge clk);
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (!full || pop) m_fifo.push_back(data_write);
      else m_ovf = 1'b1;
    end
    if (data_we && (w < RAM_BYTES)) begin
      m_ram[int'(w >> 2)] = data_write;
      m_stores = m_stores + 32'd1;
    end
    if (data_we && (w == A_STATUS) && data_write[8]) m_ovf = 1'b0;
    m_cycle = m_cycle + 32'd1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    setin('0, 1'b0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    m_reset();
    n_total++;
    if (tohost_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", tohost_valid);
    else n_pass++;
    n_total++;
    if (tohost_data !== 32'h0) $display("FAIL reset_data got %h want 0", tohost_data);
    else n_pass++;
    setin(A_CYCLE, 1'b0, '0); #1;
    n_total++;
    if (data_mem !== 32'h0) $display("FAIL reset_cycle got %h want 0", data_mem);
    else n_pass++;
    setin(A_STATUS, 1'b0, '0); #1;
    n_total++;
    if (data_mem !== 32'h2) $display("FAIL reset_status got %h want 00000002", data_mem);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_store_load();
    setin(32'h10, 1'b1, 32'h1234_5678);
    tick();
    setin(32'h10, 1'b0, '0); #1;
    n_total++;
    if (data_mem !== 32'h1234_5678) $display("FAIL store_load got %h want 12345678", data_mem);
    else n_pass++;
    setin(A_STORES, 1'b0, '0); #1;
    n_total++;
    if (data_mem !== 32'd1) $display("FAIL stores_count got %0d want 1", data_mem);
    else n_pass++;
  endtask

  task automatic test_write_then_read();
    setin(32'h20, 1'b1, 32'h5555_AAAA);
    tick();
    setin(32'h22, 1'b1, 32'h0000_000A); #1;
    n_total++;
    if (data_mem !== 32'h5555_AAAA) $display("FAIL wr_rd_same_cycle got %h want 5555aaaa", data_mem);
    else n_pass++;
    tick();
    setin(32'h20, 1'b0, '0); #1;
    n_total++;
    if (data_mem !== 32'h0000_000A) $display("FAIL wr_rd_next_cycle got %h want 0000000a", data_mem);
    else n_pass++;
  endtask

  task automatic test_cycle_counter();
    logic [31:0] c1, c2;
    setin(A_CYCLE, 1'b0, '0); #1;
    c1 = data_mem;
    n_total++;
    if (c1 !== m_cycle) $display("FAIL cycle_value got %0d want %0d", c1, m_cycle);
    else n_pass++;
    repeat (4) tick();
    #1 c2 = data_mem;
    n_total++;
    if ((c2 - c1) !== 32'd4) $display("FAIL cycle_delta got %0d want 4", c2 - c1);
    else n_pass++;
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    m_cycle = 32'hFFFF_FFFE;
    #1;
    n_total++;
    if (data_mem !== 32'hFFFF_FFFE) $display("FAIL cycle_forced got %h want fffffffe", data_mem);
    else n_pass++;
    tick();
    tick();
    #1;
    n_total++;
    if (data_mem !== 32'h0) $display("FAIL cycle_wrap got %h want 0", data_mem);
    else n_pass++;
  endtask

  task automatic test_fifo_overflow();
    tohost_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      setin(A_TOHOST, 1'b1, 32'(i));
      tick();
    end
    setin(A_STATUS, 1'b0, '0); #1;
    n_total++;
    if (data_mem !== 32'h111) $display("FAIL ovf_status got %h want 00000111", data_mem);
    else n_pass++;
    tohost_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_total++;
      if (tohost_valid !== 1'b1 || tohost_data !== 32'(i))
        $display("FAIL drain_%0d got v=%0b d=%h want v=1 d=%h", i, tohost_valid, tohost_data, 32'(i));
      else n_pass++;
      tick();
    end
    tohost_ready = 1'b0;
    #1;
    n_total++;
    if (tohost_valid !== 1'b0) $display("FAIL drain_empty got %0b want 0", tohost_valid);
    else n_pass++;
    setin(A_STATUS, 1'b1, 32'h100);
    tick();
    setin(A_STATUS, 1'b0, '0); #1;
    n_total++;
    if (data_mem !== 32'h2) $display("FAIL ovf_clear got %h want 00000002", data_mem);
    else n_pass++;
  endtask

  task automatic test_push_pop_full();
    logic [31:0] exp_order [4];
    exp_order = '{32'd13, 32'd20, 32'd21, 32'd22};
    tohost_ready = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      setin(A_TOHOST, 1'b1, 32'(i));
      tick();
    end
    tohost_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      setin(A_TOHOST, 1'b1, 32'(20 + r)); #1;
      n_total++;
      if (tohost_data !== m_head()) $display("FAIL full_pp_head%0d got %h want %h", r, tohost_data, m_head());
      else n_pass++;
      tick();
      setin(A_STATUS, 1'b0, '0); #1;
      n_total++;
      if (data_mem !== 32'h11) $display("FAIL full_pp_status%0d got %h want 00000011", r, data_mem);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      n_total++;
      if (tohost_data !== exp_order[k]) $display("FAIL wrap_order%0d got %0d want %0d", k, tohost_data, exp_order[k]);
      else n_pass++;
      tick();
    end
    tohost_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    tohost_ready = 1'b0;
    setin(A_TOHOST, 1'b1, 32'h77); tick();
    setin(A_TOHOST, 1'b1, 32'h88); tick();
    setin(A_TOHOST, 1'b1, 32'h99);
    #2 rst = 1'b0;
    #1;
    m_reset();
    n_total++;
    if (tohost_valid !== 1'b0 || tohost_data !== 32'h0)
      $display("FAIL async_rst_fifo got v=%0b d=%h want v=0 d=0", tohost_valid, tohost_data);
    else n_pass++;
    setin(A_CYCLE, 1'b0, '0); #1;
    n_total++;
    if (data_mem !== 32'h0) $display("FAIL async_rst_cycle got %h want 0", data_mem);
    else n_pass++;
    setin(32'h10, 1'b0, '0); #1;
    n_total++;
    if (data_mem !== 32'h1234_5678) $display("FAIL ram_persist got %h want 12345678", data_mem);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    setin(32'h0000_1000, 1'b1, 32'hDEAD_BEEF);
    tick();
    setin(32'h0000_1000, 1'b0, '0); #1;
    n_total++;
    if (data_mem !== 32'h0) $display("FAIL outside_load got %h want 0", data_mem);
    else n_pass++;
    setin(A_STORES, 1'b0, '0); #1;
    n_total++;
    if (data_mem !== 32'h0) $display("FAIL outside_nostore got %0d want 0", data_mem);
    else n_pass++;
    setin(A_CYCLE, 1'b0, '0); #1;
    n_total++;
    if (data_mem !== 32'd1) $display("FAIL cycle_first_edge got %0d want 1", data_mem);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] a, exp_v;
    int kind;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0, 1:    a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        2, 3:    a = A_TOHOST;
        4:       a = A_STATUS;
        5:       a = ($urandom_range(0, 1) != 0) ? A_CYCLE : A_STORES;
        default: a = 32'h0000_0800 | ($urandom & 32'h0FFF_FFFC);
      endcase
      setin(a, ($urandom_range(0, 2) != 0), $urandom);
      tohost_ready = ($urandom_range(0, 2) == 0);
      #1;
      if (m_load(a, exp_v)) begin
        n_total++;
        if (data_mem !== exp_v) $display("FAIL rnd_load%0d addr %h got %h want %h", n, a, data_mem, exp_v);
        else n_pass++;
      end
      n_total++;
      if (tohost_valid !== (m_fifo.size() > 0) || tohost_data !== m_head())
        $display("FAIL rnd_fifo%0d got v=%0b d=%h want v=%0b d=%h", n, tohost_valid, tohost_data,
                 (m_fifo.size() > 0), m_head());
      else n_pass++;
      tick();
    end
    setin(A_STATUS, 1'b0, '0); #1;
    n_total++;
    if (data_mem !== m_status()) $display("FAIL rnd_final_status got %h want %h", data_mem, m_status());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_write_then_read();
    test_cycle_counter();
    test_fifo_overflow();
    test_push_pop_full();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
